decode_stage_pipelined: RTL
===========================

Name: decode_stage_pipelined

Overview:
- Parametrised next-generation decode stage. Decodes the IF/ID instruction, reads a built-in register file with WB-to-ID bypass, and owns the ID/EX pipeline register.
- Detects load-use hazards and inserts a configurable number of bubbles through a small stall FSM.
- Honours EX back-pressure and branch flush.
- Sits between the fetch stage's IF/ID register and the execute stage.

Parameters:
- DATA_W, 32, register/data width
- REG_ADDR_W, 5, register index width
- NUM_REGS, 32, register count (at most 2**REG_ADDR_W); r0 is hardwired zero
- CTRL_W, 9, control-bit vector width
- LOAD_LATENCY, 1, bubbles inserted per load-use hazard (1..3)
- SIGN_EXT, 1, immediate extension mode: 1 = sign-extend, 0 = zero-extend

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instruction_IFID  in  32  instruction from IF/ID
- valid_IFID  in  1  IF/ID holds a real instruction
- rd_WB  in  REG_ADDR_W  writeback destination
- writeData_WB  in  DATA_W  writeback data
- regWrite_WB  in  1  writeback enable
- stall_EX  in  1  EX cannot accept; hold ID/EX
- flush  in  1  discard the ID instruction (branch taken)
- write_PC  out  1  PC update enable
- write_IFID  out  1  IF/ID update enable
- valid_IDEX  out  1  ID/EX holds a real instruction
- ctrl_IDEX  out  CTRL_W  registered control bits
- aluCtrl_IDEX  out  2  registered ALU control
- readData1_IDEX, readData2_IDEX  out  DATA_W  registered operands
- imm_IDEX  out  DATA_W  registered extended immediate
- rs_IDEX, rt_IDEX, rd_IDEX  out  REG_ADDR_W  registered register indices (rd after the regDst mux)

Behaviour:
- Reset (reset=0, asynchronous):
  - all *_IDEX outputs 0, valid_IDEX=0
  - all registers cleared to 0
  - FSM in IDLE with counter 0
  - write_PC=write_IFID=1 combinationally
- Decode (combinational):
  - opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
  - rd_ID = regDst ? [15:11] : [20:16]
  - immediate is extended per SIGN_EXT
- Register file:
  - write on the rising edge when regWrite_WB=1 and rd_WB!=0
  - reads are combinational
  - bypass: if regWrite_WB=1, rd_WB!=0 and rd_WB equals the read index, the read returns writeData_WB
  - index 0 always reads 0
- Hazard condition H:
  - valid_IFID & valid_IDEX & ctrl_IDEX[memRead] & rt_IDEX!=0 & (rt_IDEX==rs_ID | (usesRt_ID & rt_IDEX==rt_ID))
  - usesRt_ID is 1 for R-type, store and beq
- Stall FSM, states IDLE and STALL, with a 2-bit counter:
  - IDLE & H & !stall_EX: load a bubble into ID/EX (valid=0, ctrl=0). If LOAD_LATENCY>1, go to STALL with cnt=LOAD_LATENCY-2; otherwise stay in IDLE (the bubble itself clears H).
  - STALL & !stall_EX: load another bubble. If cnt==0 go to IDLE, else cnt-1.
  - write_PC = write_IFID = !(stall_EX | (IDLE & H) | STALL).
- ID/EX update priority, evaluated each rising edge:
  1. stall_EX=1: hold everything; FSM frozen; flush ignored (upstream holds flush until stall_EX=0).
  2. flush=1: bubble, FSM forced to IDLE with cnt=0.
  3. Hazard or STALL: bubble.
  4. Otherwise capture the decoded instruction, with valid_IDEX=valid_IFID and ctrl zeroed when valid_IFID=0.
- Latency: one cycle from IF/ID to ID/EX.
- Unknown opcode: ctrl=0, aluCtrl=00, valid passes through (executes as a NOP).
- Reset mid-STALL: returns to IDLE immediately; no residual bubbles.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: RTYPE=6'h00, J=6'h02, BEQ=6'h04, ADDI=6'h08, LW=6'h23, SW=6'h2B
  - control bit indices: 0 regDst, 1 branch, 2 memRead, 3 memToReg, 4 memWrite, 5 aluSrc, 6 regWrite, 7 jump, 8 reserved
  - aluCtrl codes: 00 add, 01 sub, 10 funct, 11 reserved
  - FSM state encoding
- One sub-module: decode_regfile, a parametrised register file with write-first bypass. Control and ALU-control decode stay inline as combinational functions.

Test Plan:
- Reset then `addi r1,r0,5` → after one clk, valid_IDEX=1, ctrl_IDEX[aluSrc]=1, rt_IDEX=1, imm_IDEX=5.
- Same-cycle write: rd_WB=3, writeData_WB=32'hDEAD, regWrite_WB=1, while ID reads r3 → readData1_IDEX=32'hDEAD next edge. Writing r0 leaves r0 reading 0.
- `lw r2,0(r1)` followed by `add r4,r2,r5`:
  - LOAD_LATENCY=1 → exactly 1 bubble, write_PC=0 for 1 cycle.
  - LOAD_LATENCY=3 → 3 consecutive bubbles, then add is issued with rs_IDEX=2.
- stall_EX=1 for 4 cycles mid-stream → all ID/EX outputs unchanged, write_PC=write_IFID=0. After release, the stream resumes with no loss or duplication.
- flush=1 during STALL (LOAD_LATENCY=3, second bubble) → bubble, FSM returns to IDLE, write_PC=1 the next cycle.
- SIGN_EXT=1 with imm 16'hFFFC → imm_IDEX=32'hFFFFFFFC. SIGN_EXT=0 → 32'h0000FFFC.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared constants, control-bit indices, ALU-control codes and
//               stall-FSM encoding for the pipelined decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // Primary opcodes recognised by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Bit positions inside the control vector
    localparam int CB_REGDST   = 0;
    localparam int CB_BRANCH   = 1;
    localparam int CB_MEMREAD  = 2;
    localparam int CB_MEMTOREG = 3;
    localparam int CB_MEMWRITE = 4;
    localparam int CB_ALUSRC   = 5;
    localparam int CB_REGWRITE = 6;
    localparam int CB_JUMP     = 7;
    localparam int CB_RESERVED = 8;

    // ALU-control codes handed to the execute stage
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_RSVD  = 2'b11;

    // Load-use stall FSM
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } stall_state_t;

    // What the ID/EX register does on the next edge
    typedef enum logic [1:0] {
        ACT_HOLD    = 2'b00,
        ACT_BUBBLE  = 2'b01,
        ACT_CAPTURE = 2'b10
    } idex_action_t;

    // Instructions that actually read the rt register as a source operand
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module      : decode_regfile
// Description : Two-read / one-write register file with write-first bypass.
//               Entry 0 is hardwired to zero and never stored.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_regfile #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2
);

    logic [DATA_W-1:0] regs [1:NUM_REGS-1];
    logic              wr_en;

    // Writes to index 0 are dropped so it keeps reading as zero
    assign wr_en = we && (waddr != '0);

    // Storage: cleared on reset, one entry updated per write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (waddr == REG_ADDR_W'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    // Combinational reads; a same-cycle write to the read index wins
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == REG_ADDR_W'(i)) begin
                rdata1 = regs[i];
            end
            if (raddr2 == REG_ADDR_W'(i)) begin
                rdata2 = regs[i];
            end
        end
        if (wr_en && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (wr_en && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pipelined
// Description : Instruction decode stage with register file, WB bypass,
//               load-use hazard stalling and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_pipelined
    import decode_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int NUM_REGS     = 32,
    parameter int CTRL_W       = 9,
    parameter int LOAD_LATENCY = 1,
    parameter int SIGN_EXT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instruction_IFID,
    input  logic                  valid_IFID,
    input  logic [REG_ADDR_W-1:0] rd_WB,
    input  logic [DATA_W-1:0]     writeData_WB,
    input  logic                  regWrite_WB,
    input  logic                  stall_EX,
    input  logic                  flush,
    output logic                  write_PC,
    output logic                  write_IFID,
    output logic                  valid_IDEX,
    output logic [CTRL_W-1:0]     ctrl_IDEX,
    output logic [1:0]            aluCtrl_IDEX,
    output logic [DATA_W-1:0]     readData1_IDEX,
    output logic [DATA_W-1:0]     readData2_IDEX,
    output logic [DATA_W-1:0]     imm_IDEX,
    output logic [REG_ADDR_W-1:0] rs_IDEX,
    output logic [REG_ADDR_W-1:0] rt_IDEX,
    output logic [REG_ADDR_W-1:0] rd_IDEX
);

    // Counter preload when entering STALL: the first bubble is issued from IDLE
    localparam logic [1:0] CNT_INIT = (LOAD_LATENCY > 1) ? 2'(LOAD_LATENCY - 2) : 2'd0;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [5:0] op);
        logic [CTRL_W-1:0] c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c[CB_REGDST]   = 1'b1;
                c[CB_REGWRITE] = 1'b1;
            end
            OP_LW: begin
                c[CB_MEMREAD]  = 1'b1;
                c[CB_MEMTOREG] = 1'b1;
                c[CB_ALUSRC]   = 1'b1;
                c[CB_REGWRITE] = 1'b1;
            end
            OP_SW: begin
                c[CB_MEMWRITE] = 1'b1;
                c[CB_ALUSRC]   = 1'b1;
            end
            OP_BEQ: begin
                c[CB_BRANCH]   = 1'b1;
            end
            OP_ADDI: begin
                c[CB_ALUSRC]   = 1'b1;
                c[CB_REGWRITE] = 1'b1;
            end
            OP_J: begin
                c[CB_JUMP]     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [1:0] decode_alu(input logic [5:0] op);
        logic [1:0] a;
        case (op)
            OP_RTYPE: a = ALU_FUNCT;
            OP_BEQ:   a = ALU_SUB;
            default:  a = ALU_ADD;
        endcase
        return a;
    endfunction

    // ------------------------------------------------------------------
    // Field extraction and decode
    // ------------------------------------------------------------------
    logic [5:0]            op_id;
    logic [REG_ADDR_W-1:0] rs_id;
    logic [REG_ADDR_W-1:0] rt_id;
    logic [REG_ADDR_W-1:0] rd_field;
    logic [REG_ADDR_W-1:0] rd_id;
    logic [15:0]           imm_id;
    logic [DATA_W-1:0]     imm_ext;
    logic [CTRL_W-1:0]     ctrl_id;
    logic [1:0]            alu_id;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic                  hazard;

    assign op_id    = instruction_IFID[31:26];
    assign rs_id    = REG_ADDR_W'(instruction_IFID[25:21]);
    assign rt_id    = REG_ADDR_W'(instruction_IFID[20:16]);
    assign rd_field = REG_ADDR_W'(instruction_IFID[15:11]);
    assign imm_id   = instruction_IFID[15:0];
    assign ctrl_id  = decode_ctrl(op_id);
    assign alu_id   = decode_alu(op_id);
    assign rd_id    = ctrl_id[CB_REGDST] ? rd_field : rt_id;

    if (SIGN_EXT != 0) begin : g_sign_ext
        assign imm_ext = {{(DATA_W-16){imm_id[15]}}, imm_id};
    end else begin : g_zero_ext
        assign imm_ext = {{(DATA_W-16){1'b0}}, imm_id};
    end

    decode_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (regWrite_WB),
        .waddr  (rd_WB),
        .wdata  (writeData_WB),
        .raddr1 (rs_id),
        .raddr2 (rt_id),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    // A load sitting in ID/EX whose destination feeds the instruction in ID
    assign hazard = valid_IFID && valid_IDEX && ctrl_IDEX[CB_MEMREAD]
                 && (rt_IDEX != '0)
                 && ((rt_IDEX == rs_id) || (uses_rt(op_id) && (rt_IDEX == rt_id)));

    // ------------------------------------------------------------------
    // Stall FSM
    // ------------------------------------------------------------------
    stall_state_t state, state_nxt;
    logic [1:0]   cnt, cnt_nxt;
    idex_action_t act;

    // FSM state and bubble counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and ID/EX action, in update-priority order
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act       = ACT_CAPTURE;
        if (stall_EX) begin
            act = ACT_HOLD;
        end else if (flush) begin
            act       = ACT_BUBBLE;
            state_nxt = ST_IDLE;
            cnt_nxt   = 2'd0;
        end else if (state == ST_STALL) begin
            act = ACT_BUBBLE;
            if (cnt == 2'd0) begin
                state_nxt = ST_IDLE;
            end else begin
                cnt_nxt = cnt - 2'd1;
            end
        end else if (hazard) begin
            act = ACT_BUBBLE;
            if (LOAD_LATENCY > 1) begin
                state_nxt = ST_STALL;
                cnt_nxt   = CNT_INIT;
            end
        end
    end

    // Upstream freezes whenever ID cannot hand its instruction forward
    assign write_PC   = !(stall_EX || ((state == ST_IDLE) && hazard) || (state == ST_STALL));
    assign write_IFID = write_PC;

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    // Bubbles only clear valid and control; operand fields are don't-care
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_IDEX     <= 1'b0;
            ctrl_IDEX      <= '0;
            aluCtrl_IDEX   <= 2'b00;
            readData1_IDEX <= '0;
            readData2_IDEX <= '0;
            imm_IDEX       <= '0;
            rs_IDEX        <= '0;
            rt_IDEX        <= '0;
            rd_IDEX        <= '0;
        end else begin
            case (act)
                ACT_BUBBLE: begin
                    valid_IDEX <= 1'b0;
                    ctrl_IDEX  <= '0;
                end
                ACT_CAPTURE: begin
                    valid_IDEX     <= valid_IFID;
                    ctrl_IDEX      <= valid_IFID ? ctrl_id : '0;
                    aluCtrl_IDEX   <= alu_id;
                    readData1_IDEX <= rdata1;
                    readData2_IDEX <= rdata2;
                    imm_IDEX       <= imm_ext;
                    rs_IDEX        <= rs_id;
                    rt_IDEX        <= rt_id;
                    rd_IDEX        <= rd_id;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
